uart_rx_word: RTL and testbench
===============================

// Module: uart_rx_word
// PURPOSE
//  Serial UART receiver; the receive-side counterpart of the uart_tx stage. Samples an asynchronous rx line,
//  deframes 8N-style bytes (start, LSB-first data, stop) and packs OUTPUT_DATA_WIDTH/UART_DATA_BITS
//  consecutive bytes, first byte into the LSBs, into one word with a one-cycle valid strobe.
//  Sits between the board rx pin and word-level consumers; loopback partner of the uart_tx stage.
// PARAMETERS
//  BAUD_2_CLOCK_RATIO  12000000/9600  clk cycles per bit (>= 8)
//  UART_DATA_BITS      8              data bits per frame
//  UART_STOP_BITS      2              stop bits sent by the transmitter; only the first is checked
//  OUTPUT_DATA_WIDTH   16             word width; multiple of UART_DATA_BITS
//  TIMEOUT_BITS        20             idle bit-times between bytes of one word before realignment
// PORTS
//  clk         in   1                    system clock
//  rst_n       in   1                    asynchronous active-low reset
//  rx          in   1                    serial input, idle high, asynchronous to clk
//  data_out    out  OUTPUT_DATA_WIDTH    last complete word; held until next word completes
//  data_valid  out  1                    one-cycle pulse: data_out updated this cycle
//  frame_error out  1                    one-cycle pulse: stop bit sampled low
//  busy        out  1                    high while a frame is in progress (not IDLE)
// BEHAVIOUR
//  Reset: data_out=0, data_valid=0, frame_error=0, busy=0, state=IDLE, byte index=0, sync regs=1.
//  rx passes a 2-flop synchronizer (rx_s); all decisions use rx_s. The 2-cycle input delay is fixed.
//  Let H = BAUD_2_CLOCK_RATIO/2 (floor). Let B = BAUD_2_CLOCK_RATIO.
//  IDLE:  rx_s==0 -> START, clear the bit-timer, busy=1.
//  START: wait H cycles, then sample rx_s. If 0 -> DATA. If 1 -> false start; return to IDLE, no pulse.
//  DATA:  sample rx_s every B cycles (mid-bit), shift in LSB-first. After UART_DATA_BITS samples -> STOP.
//  STOP:  sample rx_s after B cycles. Then return to IDLE in the same cycle.
//    1 -> the byte is accepted into the word slot [idx*8 +: 8], and idx increments.
//    0 -> frame_error pulses for 1 cycle. The byte and partial word are discarded, and idx=0.
//  Re-arming at mid-stop-bit means any number of stop bits (>=1) and back-to-back frames are accepted.
//  Word completion: the accepted byte has idx==last.
//    -> On the next clk edge, data_out gets the assembled word and data_valid=1 for exactly 1 cycle. idx wraps to 0.
//  Latency: data_valid rises 1 cycle after the last stop-bit sample.
//    This is ~2+H+(UART_DATA_BITS+1)*B+1 cycles after the last start edge on rx.
//  Inter-byte timeout:
//    While idx!=0 and state==IDLE, an idle counter runs.
//    Once it reaches TIMEOUT_BITS*B cycles, idx=0 and the partial word is discarded, with no pulse.
//    The counter clears on leaving IDLE.
//  data_valid and frame_error are never high in the same cycle.
//  data_out is unchanged on error or timeout.
//  Counters are sized with $clog2 and must not overflow at the defaults. Timeout counter width:
//    $clog2(TIMEOUT_BITS*B+1).
//  Mid-operation reset: immediate return to reset values. The frame in flight is lost.
//    After release, rx must be seen low again (a new falling level in IDLE) before reception restarts.
//  A line held low forever gives repeated frames with frame_error. No lock-up.
// TESTING  (use BAUD_2_CLOCK_RATIO=16, TIMEOUT_BITS=4 unless stated; drive rx with a bit-accurate model)
//  1. Send bytes 0x5A then 0xA5, 2 stop bits each.
//     -> exactly one data_valid, data_out=16'hA55A, frame_error never high, busy=0 afterwards.
//  2. rx low pulse of 5 cycles, then high.
//     -> no data_valid, no frame_error, busy returns to 0 within H+3 cycles.
//  3. Byte 0x11 with stop bit forced 0. Then 0x34 and 0x12 sent correctly.
//     -> one frame_error pulse, then one data_valid with data_out=16'h1234.
//  4. Send byte 0xFF, idle 6 bit-times (>TIMEOUT), send 0x78 then 0x56.
//     -> single data_valid with data_out=16'h5678.
//  5. Assert rst_n=0 in the middle of the data bits of byte 1 of a word, release, then send 0xCD, 0xAB.
//     -> data_out=0 after reset, then data_out=16'hABCD with one pulse.
//  6. Loopback from uart_tx (same parameters), 100 random words sent back-to-back.
//     -> every word received in order, 100 data_valid pulses, 0 frame_error.

Source files
------------

// File: rtl/uart_rx_word.sv
// -----------------------------------------------------------------------------
// uart_rx_word
//   UART receiver that deframes start / LSB-first data / stop frames from an
//   asynchronous rx line and packs OUTPUT_DATA_WIDTH/UART_DATA_BITS consecutive
//   bytes (first byte in the LSBs) into one word, announced by a one-cycle
//   data_valid strobe. Receive-side loopback partner of uart_tx.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   rx           serial input, idle high, asynchronous to clk
//   data_out     last complete word, held until the next word completes
//   data_valid   one-cycle pulse: data_out updated this cycle
//   frame_error  one-cycle pulse: stop bit sampled low (byte and partial word dropped)
//   busy         high while a frame is in progress
// -----------------------------------------------------------------------------
module uart_rx_word #(
  parameter int BAUD_2_CLOCK_RATIO = 12000000 / 9600,
  parameter int UART_DATA_BITS     = 8,
  parameter int UART_STOP_BITS     = 2,
  parameter int OUTPUT_DATA_WIDTH  = 16,
  parameter int TIMEOUT_BITS       = 20
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rx,
  output logic [OUTPUT_DATA_WIDTH-1:0] data_out,
  output logic                         data_valid,
  output logic                         frame_error,
  output logic                         busy
);

  localparam int B         = BAUD_2_CLOCK_RATIO;
  localparam int H         = B / 2;
  localparam int NUM_BYTES = OUTPUT_DATA_WIDTH / UART_DATA_BITS;
  localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int TMR_W     = $clog2(B);
  localparam int BCNT_W    = $clog2(UART_DATA_BITS + 1);
  localparam int TO_LIMIT  = TIMEOUT_BITS * B;
  localparam int TO_W      = $clog2(TO_LIMIT + 1);

  // Only the first stop bit is checked; the receiver re-arms at its midpoint,
  // so the transmitter's stop-bit count just has to be at least one.
  if (UART_STOP_BITS < 1 || (OUTPUT_DATA_WIDTH % UART_DATA_BITS) != 0 ||
      BAUD_2_CLOCK_RATIO < 8) begin : g_param_check
    $error("uart_rx_word: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                       state_q, state_d;
  logic                         rx_meta, rx_s;
  logic [TMR_W-1:0]             timer_q;
  logic [BCNT_W-1:0]            bit_cnt_q;
  logic [UART_DATA_BITS-1:0]    shift_q;
  logic [IDX_W-1:0]             idx_q;
  logic [OUTPUT_DATA_WIDTH-1:0] word_buf_q;
  logic                         word_done_q;
  logic [TO_W-1:0]              idle_cnt_q;

  logic half_tick, bit_tick, stop_sample;

  assign half_tick   = (timer_q == TMR_W'(H - 1));
  assign bit_tick    = (timer_q == TMR_W'(B - 1));
  assign stop_sample = (state_q == STOP) && bit_tick;
  assign busy        = (state_q != IDLE);

  // Two-flop synchronizer; resets to the idle (high) line level so a reset
  // release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make the two flops a true shift chain;
      // blocking ones here would collapse the synchronizer to a single stage.
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first, so every path through the case assigns state_d and
    // no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (!rx_s) state_d = START;
      START: if (half_tick) state_d = rx_s ? IDLE : DATA;   // high = false start
      DATA:  if (bit_tick && bit_cnt_q == BCNT_W'(UART_DATA_BITS - 1)) state_d = STOP;
      STOP:  if (bit_tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q     <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      idx_q       <= '0;
      // NOTE: the word buffer is a handful of flops, not a RAM, so it is reset
      // along with everything else; that keeps data_out free of X after reset.
      word_buf_q  <= '0;
      word_done_q <= 1'b0;
      idle_cnt_q  <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      word_done_q <= 1'b0;

      // Bit timer restarts on every state change and on every data sample,
      // so START measures half a bit and DATA/STOP whole bits from there.
      if (state_q == IDLE || state_d != state_q || (state_q == DATA && bit_tick))
        timer_q <= '0;
      else
        timer_q <= timer_q + 1'b1;

      if (state_q != DATA) begin
        bit_cnt_q <= '0;
      end else if (bit_tick) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
        shift_q   <= {rx_s, shift_q[UART_DATA_BITS-1:1]};
      end

      if (stop_sample) begin
        if (rx_s) begin
          for (int i = 0; i < NUM_BYTES; i++)
            if (idx_q == IDX_W'(i))
              word_buf_q[i*UART_DATA_BITS +: UART_DATA_BITS] <= shift_q;
          if (idx_q == IDX_W'(NUM_BYTES - 1)) begin
            idx_q       <= '0;
            word_done_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end else begin
          frame_error <= 1'b1;
          idx_q       <= '0;
        end
      end

      // The word is published one cycle after its last byte lands in the buffer.
      if (word_done_q) begin
        data_out   <= word_buf_q;
        data_valid <= 1'b1;
      end

      // A partially assembled word is abandoned if the line stays idle too long,
      // realigning byte slots with the transmitter's word boundaries.
      if (state_q == IDLE && idx_q != '0) begin
        if (idle_cnt_q == TO_W'(TO_LIMIT - 1)) begin
          idx_q      <= '0;
          idle_cnt_q <= '0;
        end else begin
          idle_cnt_q <= idle_cnt_q + 1'b1;
        end
      end else begin
        idle_cnt_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_word.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_word
//   Bench for uart_rx_word with BAUD_2_CLOCK_RATIO=16, TIMEOUT_BITS=4. A
//   bit-accurate serial driver sends frames; expected words go into a queue
//   that a monitor pops whenever data_valid is seen.
// -----------------------------------------------------------------------------
module tb_uart_rx_word;

  localparam int B  = 16;
  localparam int H  = B / 2;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx;
  logic [15:0] data_out;
  logic        data_valid;
  logic        frame_error;
  logic        busy;

  int          n_checks = 0;
  int          n_errors = 0;
  int          valid_cnt = 0;
  int          fe_cnt = 0;
  logic [15:0] exp_q[$];

  uart_rx_word #(
    .BAUD_2_CLOCK_RATIO(B),
    .UART_DATA_BITS    (8),
    .UART_STOP_BITS    (2),
    .OUTPUT_DATA_WIDTH (16),
    .TIMEOUT_BITS      (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_error(frame_error),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (data_valid && frame_error) check("valid_and_error_together", 1, 0);
    if (frame_error) fe_cnt++;
    if (data_valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_valid: got data_out 0x%0h with no word expected", data_out);
      end else begin
        check("word", data_out, exp_q.pop_front());
      end
    end
  end

  // Advance n rising edges, then step off the edge before driving inputs.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    rx = 1'b0;
    tick(B);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(B);
    end
    rx = stop_ok;
    tick(B);
    rx = 1'b1;
    tick(B);
  endtask

  task automatic send_word(input logic [15:0] w);
    send_byte(w[7:0], 1'b1);
    send_byte(w[15:8], 1'b1);
  endtask

  int v0, f0;
  logic [15:0] rnd;

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    tick(3);
    check("reset_data_out", data_out, 16'h0000);
    check("reset_valid", data_valid, 0);
    check("reset_frame_error", frame_error, 0);
    check("reset_busy", busy, 0);
    rst_n = 1'b1;
    tick(4);

    // 1: two good bytes form one word
    v0 = valid_cnt; f0 = fe_cnt;
    exp_q.push_back(16'hA55A);
    send_word(16'hA55A);
    tick(4);
    check("t1_valid_count", valid_cnt - v0, 1);
    check("t1_frame_errors", fe_cnt - f0, 0);
    check("t1_busy_after", busy, 0);
    check("t1_data_held", data_out, 16'hA55A);

    // 2: glitch shorter than half a bit is a false start
    v0 = valid_cnt; f0 = fe_cnt;
    rx = 1'b0;
    tick(5);
    check("t2_busy_during_glitch", busy, 1);
    rx = 1'b1;
    tick(H + 3);
    check("t2_busy_released", busy, 0);
    tick(2 * B);
    check("t2_valid_count", valid_cnt - v0, 0);
    check("t2_frame_errors", fe_cnt - f0, 0);

    // 3: bad stop bit drops the byte and the partial word before it
    v0 = valid_cnt; f0 = fe_cnt;
    send_byte(8'h99, 1'b1);
    send_byte(8'h11, 1'b0);
    tick(B);
    check("t3_frame_error_pulse", fe_cnt - f0, 1);
    check("t3_no_word_yet", valid_cnt - v0, 0);
    exp_q.push_back(16'h1234);
    send_word(16'h1234);
    tick(4);
    check("t3_valid_count", valid_cnt - v0, 1);
    check("t3_frame_errors_total", fe_cnt - f0, 1);

    // 4: inter-byte timeout discards a lone byte
    v0 = valid_cnt; f0 = fe_cnt;
    send_byte(8'hFF, 1'b1);
    tick(6 * B);
    check("t4_data_out_unchanged", data_out, 16'h1234);
    check("t4_no_word_after_timeout", valid_cnt - v0, 0);
    exp_q.push_back(16'h5678);
    send_word(16'h5678);
    tick(4);
    check("t4_valid_count", valid_cnt - v0, 1);
    check("t4_frame_errors", fe_cnt - f0, 0);

    // 5: reset in the middle of the data bits of byte 1
    v0 = valid_cnt;
    send_byte(8'h42, 1'b1);
    rx = 1'b0;
    tick(B + H);
    rx = 1'b1;
    tick(2 * B);
    rx = 1'b0;
    tick(B);
    rst_n = 1'b0;
    rx    = 1'b1;
    tick(3);
    check("t5_reset_data_out", data_out, 16'h0000);
    check("t5_reset_busy", busy, 0);
    rst_n = 1'b1;
    tick(4);
    check("t5_idle_after_release", busy, 0);
    exp_q.push_back(16'hABCD);
    send_word(16'hABCD);
    tick(4);
    check("t5_valid_count", valid_cnt - v0, 1);
    check("t5_data_out", data_out, 16'hABCD);

    // 6: 100 random words back-to-back, two stop bits each
    v0 = valid_cnt; f0 = fe_cnt;
    for (int i = 0; i < 100; i++) begin
      rnd = 16'($urandom);
      exp_q.push_back(rnd);
      send_word(rnd);
    end
    tick(4);
    check("t6_valid_count", valid_cnt - v0, 100);
    check("t6_frame_errors", fe_cnt - f0, 0);
    check("t6_busy_after", busy, 0);

    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
